// File: rtl/cl_axi_mem_rsp_pkg.sv
// Shared types and constants for the AXI4 RAM-backed responder.
package cl_axi_mem_rsp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BEAT_BYTES = 64;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/cl_axi_rsp_skid.sv
// Two-entry valid/ready buffer for read beats; entry 0 is the registered head
// that drives the R channel directly.
module cl_axi_rsp_skid #(
  parameter int W = 515
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         almost_full
);

  logic [1:0]   count;
  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop;

  assign head_valid  = (count != 2'd0);
  assign head_data   = ent0;
  assign pop         = head_valid && pop_ready;
  assign full        = (count == 2'd2);
  // One entry held plus one beat landing this cycle with nothing leaving.
  assign almost_full = (count == 2'd1) && push && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) begin
        if (count == 2'd2) begin
          ent0 <= ent1;
          if (push) ent1 <= push_data;
        end else if (push) begin
          ent0 <= push_data;
        end
      end else if (push) begin
        if (count == 2'd0) ent0 <= push_data;
        else               ent1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/cl_axi_mem_rsp.sv
// AXI4 responder backed by a read-first dual-port RAM: one write burst and one
// read burst in flight concurrently, reads run at full rate under backpressure.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; valid, once raised, is held with stable payload until accepted.
module cl_axi_mem_rsp
  import cl_axi_mem_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_BITS  = 10,
  parameter int ID_WIDTH   = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [63:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [10:0]             awuser,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  output logic [17:0]             buser,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [63:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [10:0]             aruser,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  output logic [17:0]             ruser,
  input  logic                    rready,
  output wr_state_t               wr_state_dbg,
  output rd_state_t               rd_state_dbg
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SW    = DATA_WIDTH + 3;

  assign buser = 18'd0;
  assign ruser = 18'd0;

  logic unused_inputs;
  assign unused_inputs = ^{awsize, awuser, wid, arsize, aruser, awaddr[5:0], araddr[5:0]};

  // ---------------- write path ----------------
  wr_state_t             wr_state, wr_state_nxt;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_BITS-1:0]  wr_idx;
  logic [7:0]            wr_len;
  logic                  wr_dec;
  logic [8:0]            wr_beats;
  logic                  aw_hs, w_hs, b_hs, ram_we;

  assign aw_hs        = awvalid && awready;
  assign w_hs         = wvalid && wready;
  assign b_hs         = bvalid && bready;
  assign ram_we       = w_hs && !wr_dec;
  assign wr_state_dbg = wr_state;

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs)          wr_state_nxt = W_DATA;
      W_DATA:  if (w_hs && wlast)  wr_state_nxt = W_RESP;
      W_RESP:  if (b_hs)           wr_state_nxt = W_IDLE;
      default:                     wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      wr_id    <= '0;
      wr_idx   <= '0;
      wr_len   <= '0;
      wr_dec   <= 1'b0;
      wr_beats <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      awready  <= (wr_state_nxt == W_IDLE);
      wready   <= (wr_state_nxt == W_DATA);
      bvalid   <= (wr_state_nxt == W_RESP);
      if (aw_hs) begin
        wr_id    <= awid;
        wr_idx   <= awaddr[ADDR_BITS+5:6];
        wr_len   <= awlen;
        wr_dec   <= |awaddr[63:ADDR_BITS+6];
        wr_beats <= '0;
      end
      if (w_hs) begin
        wr_idx   <= wr_idx + ADDR_BITS'(1);
        wr_beats <= wr_beats + 9'd1;
      end
      // wr_beats has not yet counted the wlast beat, so a full burst shows awlen here.
      if (w_hs && wlast) begin
        bid <= wr_id;
        if (wr_dec)                          bresp <= RESP_DECERR;
        else if (wr_beats != {1'b0, wr_len}) bresp <= RESP_SLVERR;
        else                                 bresp <= RESP_OKAY;
      end
    end
  end

  // ---------------- RAM ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_BITS-1:0]  rd_idx;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (wstrb[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read is sampled into the skid head on the same edge as any write: read-first.
  assign ram_rdata = mem[rd_idx];

  // ---------------- read path ----------------
  rd_state_t             rd_state, rd_state_nxt;
  logic [7:0]            rd_len;
  logic                  rd_dec;
  logic [8:0]            rd_issued;
  logic                  rd_room;
  logic                  ar_hs, r_hs, rd_issue, rd_issue_last;
  logic [DATA_WIDTH-1:0] rd_beat_data;
  logic [1:0]            rd_beat_resp;
  logic                  skid_full, skid_almost_full;
  logic [SW-1:0]         skid_head;

  assign ar_hs         = arvalid && arready;
  assign r_hs          = rvalid && rready;
  assign rd_issue      = (rd_state == R_BURST) && rd_room &&
                         (rd_issued != ({1'b0, rd_len} + 9'd1));
  assign rd_issue_last = (rd_issued == {1'b0, rd_len});
  assign rd_beat_data  = rd_dec ? '0 : ram_rdata;
  assign rd_beat_resp  = rd_dec ? RESP_DECERR : RESP_OKAY;
  assign rd_state_dbg  = rd_state;

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)          rd_state_nxt = R_BURST;
      R_BURST: if (r_hs && rlast)  rd_state_nxt = R_IDLE;
      default:                     rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= R_IDLE;
      arready   <= 1'b0;
      rid       <= '0;
      rd_idx    <= '0;
      rd_len    <= '0;
      rd_dec    <= 1'b0;
      rd_issued <= '0;
      rd_room   <= 1'b1;
    end else begin
      rd_state <= rd_state_nxt;
      arready  <= (rd_state_nxt == R_IDLE);
      if (ar_hs) begin
        rid       <= arid;
        rd_idx    <= araddr[ADDR_BITS+5:6];
        rd_len    <= arlen;
        rd_dec    <= |araddr[63:ADDR_BITS+6];
        rd_issued <= '0;
      end
      if (rd_issue) begin
        rd_idx    <= rd_idx + ADDR_BITS'(1);
        rd_issued <= rd_issued + 9'd1;
      end
      // Issue permission for next cycle: skid will not be holding two beats.
      rd_room <= !((skid_full && !(r_hs && !rd_issue)) || skid_almost_full);
    end
  end

  cl_axi_rsp_skid #(.W(SW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (rd_issue),
    .push_data   ({rd_beat_data, rd_beat_resp, rd_issue_last}),
    .pop_ready   (rready),
    .head_valid  (rvalid),
    .head_data   (skid_head),
    .full        (skid_full),
    .almost_full (skid_almost_full)
  );

  assign rdata = skid_head[SW-1:3];
  assign rresp = skid_head[2:1];
  assign rlast = skid_head[0];

endmodule
